// File: rtl/lsu_byte_sequencer.sv
// Byte-serial load/store sequencer between the MEM stage and a byte-wide data memory.
// Optional LSU_SIGN_EXT_EN: sign-extend word loads (default build zero-extends them).
module lsu_byte_sequencer #(
    parameter int ADDR_W    = 64,
    parameter int DATA_W    = 64,
    parameter int MEM_BYTES = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              stall,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [7:0]        mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [2:0]        idx;
    logic              write_q;
    logic              dbl_q;
    logic              err_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rbuf_q;

    logic              accept;
    logic              funct_ok;
    logic              in_range;
    logic              req_legal;
    logic              last_byte;
    logic              xfer_go;
    logic [3:0]        req_bytes;
    logic [ADDR_W:0]   end_addr;

    function automatic logic [DATA_W-1:0] format_load(input logic [DATA_W-1:0] raw,
                                                      input logic dbl);
        if (dbl) begin
            return raw;
        end
`ifdef LSU_SIGN_EXT_EN
        return {{(DATA_W-32){raw[31]}}, raw[31:0]};
`else
        return {{(DATA_W-32){1'b0}}, raw[31:0]};
`endif
    endfunction

    assign accept    = req_valid && (state == IDLE);
    assign funct_ok  = (req_funct3 == 3'b010) || (req_funct3 == 3'b011);
    assign req_bytes = (req_funct3 == 3'b011) ? 4'd8 : 4'd4;
    // One extra bit so a base near the top of the address space cannot wrap past the limit.
    assign end_addr  = {1'b0, req_addr} + {{(ADDR_W-3){1'b0}}, req_bytes};
    assign in_range  = end_addr <= (ADDR_W+1)'(MEM_BYTES);
    assign req_legal = funct_ok && in_range;
    assign last_byte = idx == (dbl_q ? 3'd7 : 3'd3);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = req_legal ? XFER : RESP;
            XFER:    if (last_byte) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                idx <= '0;
            end else if (state == XFER) begin
                idx <= idx + 3'd1;
            end
        end
    end

    // Request fields are captured once at accept; the read buffer fills one byte per XFER cycle.
    always_ff @(posedge clk) begin
        if (accept) begin
            write_q <= req_write;
            dbl_q   <= (req_funct3 == 3'b011);
            err_q   <= !req_legal;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            rbuf_q  <= '0;
        end else if ((state == XFER) && !write_q) begin
            rbuf_q[{idx, 3'b000} +: 8] <= mem_rdata;
        end
    end

    // Strobes drop as soon as reset is seen so an aborted store writes nothing further.
    assign xfer_go   = (state == XFER) && !reset;
    assign req_ready = (state == IDLE);
    assign stall     = ((state == IDLE) && req_valid) || (state == XFER);
    assign rsp_valid = (state == RESP);
    assign rsp_err   = (state == RESP) && err_q;
    assign rsp_rdata = ((state == RESP) && !err_q && !write_q) ? format_load(rbuf_q, dbl_q) : '0;
    assign mem_we    = xfer_go && write_q;
    assign mem_re    = xfer_go && !write_q;
    assign mem_addr  = (state == XFER) ? (addr_q + ADDR_W'(idx)) : '0;
    assign mem_wdata = ((state == XFER) && write_q) ? wdata_q[{idx, 3'b000} +: 8] : 8'd0;

endmodule
